// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch-address defaults, PC-unit state encoding,
// and a helper that classifies an illegal fetch address.
package cpu_defs;

    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [ADDR_W-1:0] IMEM_LO_DEF    = 32'h0000_3000;
    localparam logic [ADDR_W-1:0] IMEM_HI_DEF    = 32'h0000_6ffc;

    // RUN: no redirect pending. HOLD: a redirect is waiting for fetch to advance.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pc_state_e;

    // Misaligned or outside [lo, hi], unsigned compare.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] lo,
                                      input logic [ADDR_W-1:0] hi);
        return (a[1:0] != 2'b00) | (a < lo) | (a > hi);
    endfunction

endpackage

// File: rtl/pc_unit_prio_enc.sv
// Priority select over CHANNELS redirect requests; channel 0 wins.
//   valid   : per-channel request
//   targets : packed targets, channel i at [32*i +: 32]
//   hit     : any channel requesting
//   target  : target of the lowest-index requesting channel (0 when no hit)
module pc_prio_enc
    import cpu_defs::*;
#(
    parameter int unsigned CHANNELS = 3
) (
    input  logic [CHANNELS-1:0]        valid,
    input  logic [ADDR_W*CHANNELS-1:0] targets,
    output logic                       hit,
    output logic [ADDR_W-1:0]          target
);

    // Scan from the highest index down so the lowest asserted index is last written.
    always_comb begin
        hit    = 1'b0;
        target = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (valid[i]) begin
                hit    = 1'b1;
                target = targets[ADDR_W*i +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with exception/ERET/channel redirect selection,
// redirect hold across fetch stalls, delay-slot tracking and AdEL detection.
//   clk, reset          : clock, asynchronous active-high reset
//   stall_f, imem_ready : fetch advances when imem_ready & ~stall_f
//   req, eret, epc      : exception entry / ERET return (flush)
//   ch_valid, ch_target : prioritised control-transfer redirects
//   d_is_cti            : instruction in D is a branch/jump
//   pc_f, pc8_f         : fetch address and its link value
//   f_valid, bd_f       : word delivered this cycle / in a delay slot
//   adel_f              : fetch address misaligned or out of range
module pc_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] IMEM_LO    = IMEM_LO_DEF,
    parameter logic [31:0] IMEM_HI    = IMEM_HI_DEF,
    parameter int unsigned CHANNELS   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_f,
    input  logic                   imem_ready,
    input  logic                   req,
    input  logic                   eret,
    input  logic [31:0]            epc,
    input  logic [CHANNELS-1:0]    ch_valid,
    input  logic [32*CHANNELS-1:0] ch_target,
    input  logic                   d_is_cti,
    output logic [31:0]            pc_f,
    output logic [31:0]            pc8_f,
    output logic                   f_valid,
    output logic                   bd_f,
    output logic                   adel_f
);

    pc_state_e   state, state_next;
    logic [31:0] pending_target, pending_next;
    logic [31:0] pc_next;
    logic        bd_next;
    logic        ch_hit;
    logic [31:0] ch_win;
    logic        advance;
    logic        flush;

    assign advance = imem_ready & ~stall_f;
    assign flush   = req | eret;

    pc_prio_enc #(
        .CHANNELS (CHANNELS)
    ) u_prio (
        .valid   (ch_valid),
        .targets (ch_target),
        .hit     (ch_hit),
        .target  (ch_win)
    );

    // State, PC, pending redirect and delay-slot flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            pending_target <= '0;
            pc_f           <= RESET_PC;
            bd_f           <= 1'b0;
        end else begin
            state          <= state_next;
            pending_target <= pending_next;
            pc_f           <= pc_next;
            bd_f           <= bd_next;
        end
    end

    // Next-PC selection: req > eret > held redirect > channels > +4.
    always_comb begin
        state_next   = state;
        pending_next = pending_target;
        pc_next      = pc_f;
        bd_next      = bd_f;

        if (flush) begin
            pc_next      = req ? EXC_VECTOR : epc;
            bd_next      = 1'b0;
            state_next   = RUN;
            pending_next = '0;
        end else if (advance) begin
            bd_next = d_is_cti;
            if (state == HOLD) begin
                pc_next      = pending_target;
                state_next   = RUN;
                pending_next = '0;
            end else if (ch_hit) begin
                pc_next = ch_win;
            end else begin
                pc_next = pc_f + 32'd4;
            end
        end else if (state == RUN && ch_hit) begin
            // Fetch stuck on the delay slot: remember the redirect. In HOLD the
            // stalled branch re-presents its request, so channels are ignored.
            state_next   = HOLD;
            pending_next = ch_win;
        end
    end

    assign pc8_f   = pc_f + 32'd8;
    assign f_valid = imem_ready & ~flush;
    assign adel_f  = addr_bad(pc_f, IMEM_LO, IMEM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pc_unit;

    localparam int unsigned CH = 3;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_V  = 32'h0000_4180;
    localparam logic [31:0] LO     = 32'h0000_3000;
    localparam logic [31:0] HI     = 32'h0000_6ffc;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_f, imem_ready, req, eret, d_is_cti;
    logic [31:0]   epc;
    logic [CH-1:0] ch_valid;
    logic [32*CH-1:0] ch_target;
    logic [31:0]   pc_f, pc8_f;
    logic          f_valid, bd_f, adel_f;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_bd;
    logic [31:0] m_pend[$];

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall_f    (stall_f),
        .imem_ready (imem_ready),
        .req        (req),
        .eret       (eret),
        .epc        (epc),
        .ch_valid   (ch_valid),
        .ch_target  (ch_target),
        .d_is_cti   (d_is_cti),
        .pc_f       (pc_f),
        .pc8_f      (pc8_f),
        .f_valid    (f_valid),
        .bd_f       (bd_f),
        .adel_f     (adel_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_adel(input logic [31:0] a);
        return (a % 4 != 0) || (a < LO) || (a > HI);
    endfunction

    function automatic logic [31:0] m_first(input logic [CH-1:0] v, input logic [32*CH-1:0] t);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < int'(CH); i++) begin
            if (v[i]) begin
                r = t[32*i +: 32];
                break;
            end
        end
        return r;
    endfunction

    task automatic m_reset();
        m_pc = RST_PC;
        m_bd = 1'b0;
        m_pend.delete();
    endtask

    // Compare all outputs with the model for the current cycle.
    task automatic check_all(input string tag);
        chk({tag, ".pc_f"},    pc_f,            m_pc);
        chk({tag, ".pc8_f"},   pc8_f,           m_pc + 32'd8);
        chk({tag, ".bd_f"},    32'(bd_f),       32'(m_bd));
        chk({tag, ".f_valid"}, 32'(f_valid),    32'(imem_ready & ~(req | eret)));
        chk({tag, ".adel_f"},  32'(adel_f),     32'(m_adel(m_pc)));
    endtask

    // Drive one cycle of inputs, check outputs, clock, then advance the model.
    task automatic step(input string tag, input logic st, input logic ir,
                        input logic rq, input logic er, input logic [31:0] ep,
                        input logic [CH-1:0] cv, input logic [32*CH-1:0] ct,
                        input logic cti);
        logic adv;
        stall_f = st; imem_ready = ir; req = rq; eret = er; epc = ep;
        ch_valid = cv; ch_target = ct; d_is_cti = cti;
        #1;
        check_all(tag);
        @(posedge clk);
        adv = ir && !st;
        if (rq) begin
            m_pc = EXC_V; m_bd = 1'b0; m_pend.delete();
        end else if (er) begin
            m_pc = ep; m_bd = 1'b0; m_pend.delete();
        end else if (adv) begin
            if (m_pend.size() != 0) m_pc = m_pend.pop_front();
            else if (cv != '0)      m_pc = m_first(cv, ct);
            else                    m_pc = m_pc + 32'd4;
            m_bd = cti;
        end else if (m_pend.size() == 0 && cv != '0) begin
            m_pend.push_back(m_first(cv, ct));
        end
        #1;
    endtask

    function automatic logic [32*CH-1:0] tg(input logic [31:0] t0, input logic [31:0] t1,
                                           input logic [31:0] t2);
        return {t2, t1, t0};
    endfunction

    initial begin
        logic [32*CH-1:0] rt;
        logic [CH-1:0]    rv;
        logic [31:0]      rep;

        reset = 1'b1; stall_f = 1'b0; imem_ready = 1'b1; req = 1'b0; eret = 1'b0;
        epc = '0; ch_valid = '0; ch_target = '0; d_is_cti = 1'b0;
        m_reset();
        #12;
        chk("rst.pc_f", pc_f, 32'h0000_3000);
        chk("rst.pc8_f", pc8_f, 32'h0000_3008);
        chk("rst.bd_f", 32'(bd_f), 32'd0);
        chk("rst.adel_f", 32'(adel_f), 32'd0);
        chk("rst.f_valid", 32'(f_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Sequential fetch 3000, 3004, 3008, 300c, then reach 3010.
        for (int i = 0; i < 4; i++)
            step("seq", 0, 1, 0, 0, 0, 3'b000, '0, 0);
        chk("seq.pc3010", pc_f, 32'h0000_3010);

        // Channel 1 beats channel 2; delay-slot flag follows d_is_cti.
        step("prio", 0, 1, 0, 0, 0, 3'b110, tg(32'h0, 32'h3100, 32'h3200), 1);
        chk("prio.pc", pc_f, 32'h0000_3100);
        chk("prio.bd", 32'(bd_f), 32'd1);

        // Back to 3010 via ERET, then redirect while fetch is not ready.
        step("eret3010", 0, 1, 0, 1, 32'h3010, 3'b000, '0, 0);
        step("hold0", 0, 0, 0, 0, 0, 3'b001, tg(32'h3400, 32'h0, 32'h0), 1);
        chk("hold.pc_stays", pc_f, 32'h0000_3010);
        step("hold1", 0, 0, 0, 0, 0, 3'b010, tg(32'h0, 32'h3500, 32'h0), 0);
        step("hold2", 0, 1, 0, 0, 0, 3'b010, tg(32'h0, 32'h3500, 32'h0), 0);
        chk("hold.release", pc_f, 32'h0000_3400);

        // Exception while holding a redirect and stalled.
        step("hold3", 0, 0, 0, 0, 0, 3'b001, tg(32'h3400, 32'h0, 32'h0), 0);
        step("reqh", 1, 1, 1, 0, 0, 3'b000, '0, 1);
        chk("reqh.pc", pc_f, 32'h0000_4180);
        chk("reqh.bd", 32'(bd_f), 32'd0);
        step("after_req", 0, 1, 0, 0, 0, 3'b000, '0, 0);
        chk("after_req.run", pc_f, 32'h0000_4184);

        // req beats eret, then eret alone.
        step("req_eret", 0, 1, 1, 1, 32'h3020, 3'b000, '0, 0);
        chk("req_eret.pc", pc_f, 32'h0000_4180);
        step("eret", 0, 1, 0, 1, 32'h3020, 3'b000, '0, 0);
        chk("eret.pc", pc_f, 32'h0000_3020);

        // Address-error boundaries.
        step("t3002", 0, 1, 0, 0, 0, 3'b001, tg(32'h3002, 32'h0, 32'h0), 0);
        chk("adel.mis", 32'(adel_f), 32'd1);
        chk("adel.mis_fv", 32'(f_valid), 32'd1);
        step("t7000", 0, 1, 0, 0, 0, 3'b100, tg(32'h0, 32'h0, 32'h7000), 0);
        chk("adel.hi", 32'(adel_f), 32'd1);
        step("t6ffc", 0, 1, 0, 0, 0, 3'b100, tg(32'h0, 32'h0, 32'h6ffc), 0);
        chk("adel.edge", 32'(adel_f), 32'd0);

        // Wraparound of the +4 path.
        step("tmax", 0, 1, 0, 0, 0, 3'b001, tg(32'hffff_fffc, 32'h0, 32'h0), 0);
        step("wrap", 0, 1, 0, 0, 0, 3'b000, '0, 0);
        chk("wrap.pc", pc_f, 32'h0000_0000);

        // Reset in the middle of HOLD discards the pending redirect.
        step("rh0", 0, 0, 0, 0, 0, 3'b001, tg(32'h3400, 32'h0, 32'h0), 0);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        m_reset();
        chk("rh.pc", pc_f, 32'h0000_3000);
        step("rh1", 0, 1, 0, 0, 0, 3'b000, '0, 0);
        chk("rh.no_pend", pc_f, 32'h0000_3004);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 1) == 0) ? 3'b000 : CH'($urandom_range(1, 7));
            for (int c = 0; c < int'(CH); c++) begin
                if ($urandom_range(0, 7) == 0) rt[32*c +: 32] = $urandom();
                else rt[32*c +: 32] = LO + 32'($urandom_range(0, 12'hfff) << 2);
            end
            rep = ($urandom_range(0, 3) == 0) ? $urandom() : LO + 32'($urandom_range(0, 12'hfff) << 2);
            step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, rep,
                 rv, rt, 1'($urandom_range(0, 1)));
        end
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
